sta_result_receiver: RTL

- Captures the result stream the STA core emits: worst_delay plus path node sequence under out_valid.
- Buffers the path into a 16-entry node store and checks frame integrity (start node, end node, length, optional duplicate nodes).
- Presents the checked result to downstream logic over a valid/ready handshake, with random-access read of the stored path.
- Sits between the STA core output and the on-chip result checker/readout logic.

---
 rtl/sta_result_receiver.sv | 281 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sta_result_receiver.sv
// -----------------------------------------------------------------------------
// sta_result_receiver
//
// Captures one result frame from the STA core, stores the path nodes in a
// DEPTH-entry buffer, and checks the frame for integrity. The checked result
// is then offered downstream over a valid/ready handshake. While the result
// is offered, the stored path can be read at random through rd_addr/rd_data.
//
// A frame is a run of consecutive in_valid cycles. in_worst_delay is sampled
// only on the first of those cycles, and each cycle carries one path node.
//
// Integrity checks:
//   err_start : first node is not START_NODE
//   err_end   : last *stored* node is not END_NODE
//   err_ovf   : frame carried more than DEPTH nodes (extra nodes are dropped)
//   err_dup   : a stored node index appeared twice in the frame
//               (only when DUP_CHECK_EN is defined; otherwise tied to 0)
//
// Build option: define DUP_CHECK_EN to enable the duplicate-node check.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   in_valid         STA out_valid, high for the whole frame
//   in_worst_delay   STA worst_delay, sampled on the first frame cycle
//   in_path          STA path node, one per in_valid cycle
//   result_valid     result available (REPORT state)
//   result_ready     downstream accepts the result
//   result_delay     captured worst delay
//   result_len       number of stored nodes (1..DEPTH) while reporting
//   err_start/end/ovf/dup  integrity flags
//   rd_addr, rd_data path buffer read port (0 outside REPORT or past length)
//   drop_pulse       one-cycle pulse when a frame starts while a result is held
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module sta_result_receiver #(
    parameter int NODE_W     = 4,
    parameter int DEPTH      = 16,
    parameter int DELAY_W    = 8,
    parameter int START_NODE = 0,
    parameter int END_NODE   = 1,
    localparam int CNT_W     = $clog2(DEPTH + 1),
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [DELAY_W-1:0] in_worst_delay,
    input  logic [NODE_W-1:0]  in_path,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [DELAY_W-1:0] result_delay,
    output logic [CNT_W-1:0]   result_len,
    output logic               err_start,
    output logic               err_end,
    output logic               err_ovf,
    output logic               err_dup,
    input  logic [NODE_W-1:0]  rd_addr,
    output logic [NODE_W-1:0]  rd_data,
    output logic               drop_pulse
);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        REPORT
    } state_t;

    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [NODE_W-1:0] START_C = NODE_W'(START_NODE);
    localparam logic [NODE_W-1:0] END_C   = NODE_W'(END_NODE);

    state_t             state_q, state_nxt;
    logic [CNT_W-1:0]   count_q;
    logic [NODE_W-1:0]  last_node_q;
    logic [DELAY_W-1:0] delay_q;
    logic               err_start_q, err_end_q, err_ovf_q;
    logic               drop_q;
    // Set while the current in_valid burst must be ignored (it began while a
    // result was held, or it was already in flight when reset released).
    // Cleared by any cycle with in_valid low, which re-arms frame capture.
    logic               ignore_q;
    logic [NODE_W-1:0]  mem [DEPTH];

    // FSM strobes
    logic frame_start;   // first node of an accepted frame (IDLE)
    logic node_store;    // further node written into the buffer
    logic node_ovf;      // node arrived with the buffer full, dropped
    logic frame_end;     // in_valid fell, frame complete
    logic handshake;     // result consumed downstream
    logic drop_nxt;      // frame start seen while reporting

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignment so every
            // register samples pre-edge values regardless of block order.
            state_q <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and control strobes
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case statement can leave one unassigned (no latches).
        state_nxt   = state_q;
        frame_start = 1'b0;
        node_store  = 1'b0;
        node_ovf    = 1'b0;
        frame_end   = 1'b0;
        handshake   = 1'b0;
        drop_nxt    = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid && !ignore_q) begin
                    frame_start = 1'b1;
                    state_nxt   = RECV;
                end
            end

            RECV: begin
                if (in_valid) begin
                    if (count_q < DEPTH_C) begin
                        node_store = 1'b1;
                    end else begin
                        node_ovf = 1'b1;
                    end
                end else begin
                    frame_end = 1'b1;
                    state_nxt = REPORT;
                end
            end

            REPORT: begin
                // in_valid with ignore_q clear is the first cycle of a new
                // burst, i.e. a rising edge of in_valid.
                if (in_valid && !ignore_q) begin
                    drop_nxt = 1'b1;
                end
                if (result_ready) begin
                    handshake = 1'b1;
                    state_nxt = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Frame bookkeeping and integrity flags
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            last_node_q <= '0;
            delay_q     <= '0;
            err_start_q <= 1'b0;
            err_end_q   <= 1'b0;
            err_ovf_q   <= 1'b0;
            drop_q      <= 1'b0;
            // Starts set so a burst already running at reset release is not
            // captured mid-frame; the first low cycle re-arms the block.
            ignore_q    <= 1'b1;
        end else begin
            drop_q   <= drop_nxt;
            ignore_q <= in_valid && (ignore_q || (state_q == REPORT));

            if (frame_start) begin
                delay_q     <= in_worst_delay;
                count_q     <= CNT_W'(1);
                last_node_q <= in_path;
                err_start_q <= (in_path != START_C);
                err_end_q   <= 1'b0;
                err_ovf_q   <= 1'b0;
            end

            if (node_store) begin
                count_q     <= count_q + 1'b1;
                last_node_q <= in_path;
            end

            if (node_ovf) begin
                err_ovf_q <= 1'b1;
            end

            // last_node_q mirrors entry[count-1], so no buffer read is needed.
            if (frame_end) begin
                err_end_q <= (last_node_q != END_C);
            end

            if (handshake) begin
                count_q     <= '0;
                err_start_q <= 1'b0;
                err_end_q   <= 1'b0;
                err_ovf_q   <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Path buffer
    // -------------------------------------------------------------------------
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;

    assign wr_en   = frame_start || node_store;
    assign wr_addr = frame_start ? '0 : count_q[ADDR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the buffer is small and must read as zero after reset,
            // so it is built from resettable flops rather than a RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= in_path;
        end
    end

    // -------------------------------------------------------------------------
    // Optional duplicate-node check
    // -------------------------------------------------------------------------
`ifdef DUP_CHECK_EN
    logic [DEPTH-1:0] visited_q;
    logic             err_dup_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            visited_q <= '0;
            err_dup_q <= 1'b0;
        end else begin
            if (frame_start) begin
                // Fresh mask holding only the first node.
                visited_q          <= '0;
                visited_q[in_path] <= 1'b1;
                err_dup_q          <= 1'b0;
            end
            // Only nodes that are actually stored take part in the check;
            // overflow nodes are discarded unseen.
            if (node_store) begin
                visited_q[in_path] <= 1'b1;
                if (visited_q[in_path]) begin
                    err_dup_q <= 1'b1;
                end
            end
            if (handshake) begin
                err_dup_q <= 1'b0;
            end
        end
    end

    assign err_dup = err_dup_q;
`else
    assign err_dup = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign result_valid = (state_q == REPORT);
    assign result_delay = delay_q;
    assign result_len   = (state_q == REPORT) ? count_q : '0;
    assign err_start    = err_start_q;
    assign err_end      = err_end_q;
    assign err_ovf      = err_ovf_q;
    assign drop_pulse   = drop_q;

    // Stale entries beyond the current length are hidden, not cleared.
    assign rd_data = ((state_q == REPORT) && (CNT_W'(rd_addr) < count_q))
                     ? mem[ADDR_W'(rd_addr)] : '0;

endmodule
